// File: rtl/clk_ctrl_buttons_pkg.sv
// Shared constants and types for the clock-control front-panel button conditioner.
// Channel indices select bits of the debounced level vector.
package clk_ctrl_buttons_pkg;

    localparam int unsigned BTN_START_STOP = 0;
    localparam int unsigned BTN_STEP       = 1;
    localparam int unsigned BTN_SPEED      = 2;
    localparam int unsigned BTN_COUNT      = 3;

    // 10 ms at 125 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1250000;

    typedef struct packed {
        logic level;
        logic press;
    } btn_out_t;

endpackage

// File: rtl/btn_debounce.sv
// Single button channel: 2-FF synchroniser, hold-time debounce counter,
// debounced level register and a registered one-cycle press pulse.
module btn_debounce
    import clk_ctrl_buttons_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 32
) (
    input  logic     clk_i,
    input  logic     rst,
    input  logic     btn_i,
    output btn_out_t out_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample matching the accepted level restarts the hold window, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches stable_q.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            press_d  = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign out_o.level = stable_q;
    assign out_o.press = press_q;

endmodule

// File: rtl/clk_ctrl_buttons.sv
// Front-panel button conditioner feeding the CPU clock generator: polarity
// normalisation, three independent debounce channels and output mapping.
module clk_ctrl_buttons
    import clk_ctrl_buttons_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 btn_start_stop_i,
    input  logic                 btn_step_i,
    input  logic                 btn_speed_i,
    output logic                 clk_start_stop_o,
    output logic                 clk_step_o,
    output logic                 clk_speed_o,
    output logic [BTN_COUNT-1:0] btn_level_o
);

    logic [BTN_COUNT-1:0] raw;
    logic [BTN_COUNT-1:0] pressed;
    logic [BTN_COUNT-1:0] level;
    logic [BTN_COUNT-1:0] press;
    btn_out_t             chan_out [BTN_COUNT];
    logic                 unused_step_press;

    assign raw     = {btn_speed_i, btn_step_i, btn_start_stop_i};
    assign pressed = raw ^ {BTN_COUNT{ACTIVE_LOW}};

    for (genvar g = 0; g < BTN_COUNT; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk_i (clk_i),
            .rst   (rst),
            .btn_i (pressed[g]),
            .out_o (chan_out[g])
        );
        assign level[g] = chan_out[g].level;
        assign press[g] = chan_out[g].press;
    end

    // Single-step is consumed as a level by the clock module; its pulse has no sink.
    assign unused_step_press = press[BTN_STEP];

    assign clk_start_stop_o = press[BTN_START_STOP];
    assign clk_speed_o      = press[BTN_SPEED];
    assign clk_step_o       = level[BTN_STEP];
    assign btn_level_o      = level;

endmodule

// File: tb/tb_clk_ctrl_buttons.sv
// Self-checking bench for clk_ctrl_buttons with DEBOUNCE_CYCLES=4, active-low buttons.
module tb_clk_ctrl_buttons;

    localparam int DEB = 4;

    logic       clk_i = 1'b0;
    logic       rst;
    logic       btn_start_stop_i, btn_step_i, btn_speed_i;
    logic       clk_start_stop_o, clk_step_o, clk_speed_o;
    logic [2:0] btn_level_o;

    clk_ctrl_buttons #(
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1'b1),
        .CNT_W           (8)
    ) dut (
        .clk_i            (clk_i),
        .rst              (rst),
        .btn_start_stop_i (btn_start_stop_i),
        .btn_step_i       (btn_step_i),
        .btn_speed_i      (btn_speed_i),
        .clk_start_stop_o (clk_start_stop_o),
        .clk_step_o       (clk_step_o),
        .clk_speed_o      (clk_speed_o),
        .btn_level_o      (btn_level_o)
    );

    always #5 clk_i = ~clk_i;

    // raw = {speed, step, start_stop}; exp = {ss_pulse, step_lvl, sp_pulse, level[2:0]}
    typedef struct {
        logic [2:0] raw;
        logic       r;
        logic [5:0] exp;
    } vec_t;

    vec_t       tab [20];
    logic [5:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         edge_n = -1;

    // Reference: a channel flips once the last DEB synchronised samples all
    // disagree with the accepted level (samples lag the raw pin by one edge).
    logic [15:0] m_hist [3];
    logic [2:0]  m_stable;

    int   ss_pulse_edge, sp_pulse_edge, n_ss, n_sp;
    int   step_rise_edge, step_fall_edge;
    logic prev_step, lvl2_seen;

    task automatic model_edge(input logic [2:0] pressed, input logic r, output logic [5:0] e);
        logic [2:0]     p;
        logic [DEB-1:0] win;
        logic           flip;
        p = 3'b000;
        if (r) begin
            for (int ch = 0; ch < 3; ch++) m_hist[ch] = 16'h0;
            m_stable = 3'b000;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                win  = m_hist[ch][DEB:1];
                flip = m_stable[ch] ? (win == '0) : (win == {DEB{1'b1}});
                if (flip) begin
                    m_stable[ch] = ~m_stable[ch];
                    p[ch]        = m_stable[ch];
                end
                m_hist[ch] = {m_hist[ch][14:0], pressed[ch]};
            end
        end
        e = {p[0], m_stable[1], p[2], m_stable};
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clear_track();
        ss_pulse_edge  = -1;
        sp_pulse_edge  = -1;
        step_rise_edge = -1;
        step_fall_edge = -1;
        n_ss = 0;
        n_sp = 0;
        lvl2_seen = 1'b0;
    endtask

    task automatic step(input logic [2:0] raw, input logic r, input logic use_tab,
                        input logic [5:0] tab_exp, input string tag);
        logic [5:0] mexp, obs, e;
        @(negedge clk_i);
        {btn_speed_i, btn_step_i, btn_start_stop_i} = raw;
        rst = r;
        model_edge(~raw, r, mexp);
        exp_q.push_back(use_tab ? tab_exp : mexp);
        @(posedge clk_i);
        #1;
        edge_n++;
        obs = {clk_start_stop_o, clk_step_o, clk_speed_o, btn_level_o};
        e   = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s edge %0d: outputs got %b want %b", tag, edge_n, obs, e);
        end
        if (obs[5]) begin n_ss++; if (ss_pulse_edge < 0) ss_pulse_edge = edge_n; end
        if (obs[3]) begin n_sp++; if (sp_pulse_edge < 0) sp_pulse_edge = edge_n; end
        if (obs[4] && !prev_step && step_rise_edge < 0) step_rise_edge = edge_n;
        if (!obs[4] && prev_step && step_fall_edge < 0) step_fall_edge = edge_n;
        prev_step = obs[4];
        if (obs[2]) lvl2_seen = 1'b1;
    endtask

    task automatic run(input logic [2:0] raw, input logic r, input int n, input string tag);
        for (int i = 0; i < n; i++) step(raw, r, 1'b0, 6'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k, j;
        rst = 1'b1;
        {btn_speed_i, btn_step_i, btn_start_stop_i} = 3'b111;
        for (int ch = 0; ch < 3; ch++) m_hist[ch] = 16'h0;
        m_stable  = 3'b000;
        prev_step = 1'b0;
        clear_track();

        // Reset and clean start/stop press (pressed edges 4..11, released from 12).
        for (int r = 0; r < 20; r++) begin
            tab[r].raw = (r >= 4 && r < 12) ? 3'b110 : 3'b111;
            tab[r].r   = (r < 3);
            tab[r].exp = 6'b000000;
        end
        tab[9].exp = 6'b100001;
        for (int r = 10; r <= 16; r++) tab[r].exp = 6'b000001;
        for (int r = 0; r < 20; r++) step(tab[r].raw, tab[r].r, 1'b1, tab[r].exp, "table");

        // Bounce on speed: 2-cycle runs never accepted.
        clear_track();
        for (int i = 0; i < 20; i++)
            step({((i / 2) % 2 == 0) ? 1'b0 : 1'b1, 2'b11}, 1'b0, 1'b0, 6'b0, "bounce");
        run(3'b111, 1'b0, 10, "bounce_settle");
        check_int("bounce_sp_pulses", n_sp, 0);
        check_int("bounce_level2", int'(lvl2_seen), 0);

        // Step held 50 cycles.
        clear_track();
        step(3'b101, 1'b0, 1'b0, 6'b0, "step_hold");
        k = edge_n;
        run(3'b101, 1'b0, 49, "step_hold");
        step(3'b111, 1'b0, 1'b0, 6'b0, "step_rel");
        j = edge_n;
        run(3'b111, 1'b0, 9, "step_rel");
        check_int("step_rise_edge", step_rise_edge, k + DEB + 1);
        check_int("step_fall_edge", step_fall_edge, j + DEB + 1);
        check_int("step_no_ss_pulse", n_ss, 0);
        check_int("step_no_sp_pulse", n_sp, 0);

        // All three pressed together, then held through a 2-cycle reset.
        clear_track();
        step(3'b000, 1'b0, 1'b0, 6'b0, "simul");
        k = edge_n;
        run(3'b000, 1'b0, 9, "simul");
        check_int("simul_ss_edge", ss_pulse_edge, k + DEB + 1);
        check_int("simul_sp_edge", sp_pulse_edge, k + DEB + 1);
        check_int("simul_step_edge", step_rise_edge, k + DEB + 1);
        check_int("simul_ss_count", n_ss, 1);
        run(3'b000, 1'b1, 2, "held_rst");
        clear_track();
        step(3'b000, 1'b0, 1'b0, 6'b0, "held_after");
        j = edge_n;
        run(3'b000, 1'b0, 8, "held_after");
        check_int("held_ss_edge", ss_pulse_edge, j + DEB + 1);
        check_int("held_sp_edge", sp_pulse_edge, j + DEB + 1);
        check_int("held_ss_count", n_ss, 1);
        run(3'b111, 1'b0, 8, "held_release");

        // Reset in the middle of a start/stop debounce.
        clear_track();
        run(3'b110, 1'b0, 3, "mid_rst");
        step(3'b110, 1'b1, 1'b0, 6'b0, "mid_rst");
        step(3'b110, 1'b0, 1'b0, 6'b0, "mid_after");
        j = edge_n;
        run(3'b110, 1'b0, 8, "mid_after");
        check_int("mid_ss_edge", ss_pulse_edge, j + DEB + 1);
        check_int("mid_ss_count", n_ss, 1);
        run(3'b111, 1'b0, 8, "mid_release");

        // Reset on the edge the pulse would fire: reset wins.
        clear_track();
        run(3'b110, 1'b0, 5, "rst_wins");
        step(3'b110, 1'b1, 1'b0, 6'b0, "rst_wins");
        check_int("rst_wins_no_pulse", n_ss, 0);
        step(3'b110, 1'b0, 1'b0, 6'b0, "rst_wins_after");
        j = edge_n;
        run(3'b110, 1'b0, 8, "rst_wins_after");
        check_int("rst_wins_ss_edge", ss_pulse_edge, j + DEB + 1);
        check_int("rst_wins_ss_count", n_ss, 1);
        run(3'b111, 1'b0, 8, "final_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
